register_bank: RTL and testbench

Parametrised multi-register storage block for the datapath. It replaces banks of individual enable/clear registers with one array of NUM_REGS registers, each DATA_WIDTH bits wide. It has one write port, two combinational read ports with write-through bypass, and an optional hardwired-zero R0. A sequential scrub engine zeroes the array one register per cycle without asserting reset.

---
 rtl/register_bank.sv | 146 ++++++++++++++
 tb/tb_register_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// rtl/register_bank.sv - parametrised register array with bypassed dual read ports and a zeroing scrub engine
//
// Purpose:
//   NUM_REGS x DATA_WIDTH register array with one write port, two
//   combinational read ports (write-through bypass), an optional
//   hardwired-zero R0, and a sequential scrub engine that zeroes the array
//   one register per cycle.
//
// Ports:
//   clock        - rising-edge clock for all state
//   clear        - synchronous active-low reset (registers <= INIT, FSM idle)
//   enable       - write enable (dropped while busy)
//   write_addr   - write register index
//   BusMuxOut    - write data
//   read_addr_a  - read port A index
//   read_addr_b  - read port B index
//   BusMuxIn_A   - read port A data
//   BusMuxIn_B   - read port B data
//   scrub_start  - request a full-array zero scrub (ignored while busy)
//   busy         - scrub in progress
//   scrub_done   - one-cycle pulse after the last register is zeroed

module register_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter bit                    R0_ZERO    = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [DATA_WIDTH-1:0] BusMuxIn_A,
  output logic [DATA_WIDTH-1:0] BusMuxIn_B,
  input  logic                  scrub_start,
  output logic                  busy,
  output logic                  scrub_done
);

  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   REG_COUNT = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] scrub_ptr;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic wr_in_range;
  logic wr_masked_r0;
  logic write_ok;
  logic a_zero;
  logic b_zero;

  // Outputs decode state only, so they carry no input-to-output path.
  assign busy       = (state == SCRUB);
  assign scrub_done = (state == DONE);

  assign wr_in_range  = ({1'b0, write_addr} < REG_COUNT);
  assign wr_masked_r0 = R0_ZERO && (write_addr == '0);
  // Single qualifier shared by the array update and both bypass paths,
  // so a dropped write can never show up on a read port.
  assign write_ok     = enable && !busy && wr_in_range && !wr_masked_r0;

  assign a_zero = ({1'b0, read_addr_a} >= REG_COUNT) || (R0_ZERO && (read_addr_a == '0));
  assign b_zero = ({1'b0, read_addr_b} >= REG_COUNT) || (R0_ZERO && (read_addr_b == '0));

  // Zero rules outrank bypass; bypass outranks stored contents.
  always_comb begin
    BusMuxIn_A = '0;
    if (a_zero) begin
      BusMuxIn_A = '0;
    end else if (write_ok && (write_addr == read_addr_a)) begin
      BusMuxIn_A = BusMuxOut;
    end else begin
      BusMuxIn_A = regs[read_addr_a];
    end
  end

  always_comb begin
    BusMuxIn_B = '0;
    if (b_zero) begin
      BusMuxIn_B = '0;
    end else if (write_ok && (write_addr == read_addr_b)) begin
      BusMuxIn_B = BusMuxOut;
    end else begin
      BusMuxIn_B = regs[read_addr_b];
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (scrub_start) begin
          next_state = SCRUB;
        end else begin
          next_state = IDLE;
        end
      end
      SCRUB: begin
        if (scrub_ptr == LAST_PTR) begin
          next_state = DONE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state     <= IDLE;
      scrub_ptr <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= INIT;
      end
    end else begin
      state <= next_state;
      if (state == SCRUB) begin
        regs[scrub_ptr] <= '0;
        // Hold at the terminal index; the next scrub reloads from zero.
        if (scrub_ptr != LAST_PTR) begin
          scrub_ptr <= scrub_ptr + 1'b1;
        end
      end else begin
        if (scrub_start) begin
          scrub_ptr <= '0;
        end
        if (write_ok) begin
          regs[write_addr] <= BusMuxOut;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - self-checking bench for register_bank (12- and 16-entry instances)

module tb_register_bank;

  localparam logic [31:0] INITV = 32'hA5A5A5A5;

  logic        clock = 1'b0;
  logic        clear;
  logic        enable;
  logic [3:0]  write_addr;
  logic [31:0] BusMuxOut;
  logic [3:0]  read_addr_a;
  logic [3:0]  read_addr_b;
  logic        scrub_start;

  logic [31:0] a12, b12, a16, b16;
  logic        busy12, busy16, done12, done16;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  register_bank #(
    .DATA_WIDTH(32), .NUM_REGS(12), .ADDR_WIDTH(4), .R0_ZERO(1'b1), .INIT(INITV)
  ) dut12 (
    .clock(clock), .clear(clear), .enable(enable), .write_addr(write_addr),
    .BusMuxOut(BusMuxOut), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .BusMuxIn_A(a12), .BusMuxIn_B(b12), .scrub_start(scrub_start),
    .busy(busy12), .scrub_done(done12)
  );

  register_bank #(
    .DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4), .R0_ZERO(1'b1), .INIT(INITV)
  ) dut16 (
    .clock(clock), .clear(clear), .enable(enable), .write_addr(write_addr),
    .BusMuxOut(BusMuxOut), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .BusMuxIn_A(a16), .BusMuxIn_B(b16), .scrub_start(scrub_start),
    .busy(busy16), .scrub_done(done16)
  );

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, (k == 0) ? 12 : 16, act, exp);
    end
  endtask

  // Behavioural model: k=0 is the 12-entry bank, k=1 the 16-entry bank.
  // Scrub is tracked as a count of busy cycles still owed.
  logic [31:0] mem [2][16];
  int          busy_left [2];
  bit          done_now [2];
  bit          model_valid = 1'b0;

  function automatic int nregs(input int k);
    return (k == 0) ? 12 : 16;
  endfunction

  function automatic bit legal(input int k, input logic [3:0] a);
    return (int'(a) < nregs(k)) && (a != 4'd0);
  endfunction

  function automatic logic [31:0] expect_read(input int k, input logic [3:0] a);
    if (!legal(k, a)) return 32'h0;
    if (busy_left[k] == 0 && enable && legal(k, write_addr) && write_addr == a) return BusMuxOut;
    return mem[k][a];
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!clear) begin
        for (int r = 0; r < 16; r++) mem[k][r] = INITV;
        busy_left[k] = 0;
        done_now[k]  = 1'b0;
      end else if (model_valid) begin
        if (busy_left[k] > 0) begin
          mem[k][nregs(k) - busy_left[k]] = 32'h0;
          busy_left[k]--;
          done_now[k] = (busy_left[k] == 0);
        end else begin
          done_now[k] = 1'b0;
          if (enable && legal(k, write_addr)) mem[k][write_addr] = BusMuxOut;
          if (scrub_start) busy_left[k] = nregs(k);
        end
      end
    end
    if (!clear) model_valid = 1'b1;
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("read_a", 0, a12, expect_read(0, read_addr_a));
      check("read_b", 0, b12, expect_read(0, read_addr_b));
      check("busy", 0, 32'(busy12), 32'(busy_left[0] > 0));
      check("scrub_done", 0, 32'(done12), 32'(done_now[0]));
      check("read_a", 1, a16, expect_read(1, read_addr_a));
      check("read_b", 1, b16, expect_read(1, read_addr_b));
      check("busy", 1, 32'(busy16), 32'(busy_left[1] > 0));
      check("scrub_done", 1, 32'(done16), 32'(done_now[1]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cnt12, cnt16, dcnt12, dcnt16, dat12, dat16;
    clear = 1'b0; enable = 1'b0; write_addr = 4'd0; BusMuxOut = 32'h0;
    read_addr_a = 4'd0; read_addr_b = 4'd0; scrub_start = 1'b0;
    tick();
    tick();

    // Reset contents
    clear = 1'b1; read_addr_a = 4'd3; read_addr_b = 4'd0;
    #2;
    check("rst_r3", 0, a12, INITV);
    check("rst_r3", 1, a16, INITV);
    check("rst_r0", 0, b12, 32'h0);
    check("rst_r0", 1, b16, 32'h0);
    check("rst_busy", 1, 32'(busy16), 32'h0);
    tick();

    // Write then read, then same-cycle bypass
    enable = 1'b1; write_addr = 4'd5; BusMuxOut = 32'hDEADBEEF;
    tick();
    enable = 1'b0; read_addr_a = 4'd5;
    #2;
    check("wr_rd", 0, a12, 32'hDEADBEEF);
    check("wr_rd", 1, a16, 32'hDEADBEEF);
    tick();
    enable = 1'b1; BusMuxOut = 32'h12345678; read_addr_b = 4'd5;
    #2;
    check("bypass_b", 1, b16, 32'h12345678);
    check("bypass_a", 0, a12, 32'h12345678);
    tick();

    // R0 and out-of-range writes
    write_addr = 4'd0; BusMuxOut = 32'hFFFFFFFF;
    tick();
    write_addr = 4'd13;
    tick();
    enable = 1'b0; read_addr_a = 4'd0; read_addr_b = 4'd13;
    #2;
    check("r0_write", 0, a12, 32'h0);
    check("oor_write", 0, b12, 32'h0);
    check("r0_write", 1, a16, 32'h0);
    check("r13_write", 1, b16, 32'hFFFFFFFF);
    tick();
    read_addr_a = 4'd11; read_addr_b = 4'd12;
    #2;
    check("r11_kept", 0, a12, INITV);
    check("oor_read12", 0, b12, 32'h0);
    check("r12_read", 1, b16, INITV);
    tick();

    // Fill 1..15 with nonzero patterns
    for (int i = 1; i < 16; i++) begin
      enable = 1'b1; write_addr = 4'(i); BusMuxOut = 32'(i) * 32'h11111111;
      tick();
    end
    enable = 1'b0; read_addr_a = 4'd9; read_addr_b = 4'd15;

    // Scrub with a dropped write and an ignored second start
    scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    cnt12 = 0; cnt16 = 0; dcnt12 = 0; dcnt16 = 0; dat12 = -1; dat16 = -1;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (busy12) cnt12++;
      if (busy16) cnt16++;
      if (done12) begin dcnt12++; dat12 = c; end
      if (done16) begin dcnt16++; dat16 = c; end
      enable = (c == 3); write_addr = 4'd14; BusMuxOut = 32'hCAFEF00D;
      scrub_start = (c == 5);
      tick();
    end
    enable = 1'b0; scrub_start = 1'b0;
    check("scrub_busy_cycles", 0, 32'(cnt12), 32'd12);
    check("scrub_busy_cycles", 1, 32'(cnt16), 32'd16);
    check("scrub_done_count", 0, 32'(dcnt12), 32'd1);
    check("scrub_done_count", 1, 32'(dcnt16), 32'd1);
    check("scrub_done_cycle", 0, 32'(dat12), 32'd12);
    check("scrub_done_cycle", 1, 32'(dat16), 32'd16);
    read_addr_a = 4'd14; read_addr_b = 4'd7;
    #2;
    check("scrub_lost_write", 1, a16, 32'h0);
    check("scrub_zero_r7", 0, b12, 32'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      read_addr_a = 4'(i); read_addr_b = 4'(15 - i);
      tick();
    end

    // Reset in the middle of a scrub
    enable = 1'b1; write_addr = 4'd3; BusMuxOut = 32'h00000033;
    tick();
    write_addr = 4'd7; BusMuxOut = 32'h00000077;
    tick();
    enable = 1'b0; scrub_start = 1'b1;
    tick();
    scrub_start = 1'b0;
    repeat (6) tick();
    clear = 1'b0;
    tick();
    clear = 1'b1; read_addr_a = 4'd7; read_addr_b = 4'd1;
    #2;
    check("abort_busy", 0, 32'(busy12), 32'h0);
    check("abort_busy", 1, 32'(busy16), 32'h0);
    check("abort_r7", 1, a16, INITV);
    check("abort_r1", 0, b12, INITV);
    dcnt12 = 0;
    for (int c = 0; c < 30; c++) begin
      #2;
      if (done12 || done16) dcnt12++;
      read_addr_a = 4'(c % 16);
      tick();
    end
    check("abort_no_done", 1, 32'(dcnt12), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
